// File: rtl/mips_mult_ctrl_if.sv
// Bundle between the MULTU controller, its requester and the shared 32-bit ALU.
// slave = controller side, master = requester/datapath/ALU side.
interface mips_mult_ctrl_if;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_own;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic        alu_cout;

  modport slave (
    input  start, mcand, mplier, alu_r, alu_cout,
    output busy, done, hi, lo, alu_own, alu_op, alu_a, alu_b
  );

  modport master (
    output start, mcand, mplier, alu_r, alu_cout,
    input  busy, done, hi, lo, alu_own, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/mips_mult_ctrl.sv
// Multi-cycle unsigned multiply (MULTU) controller: borrows the shared ALU for
// N_ITER shift-add cycles and leaves the 64-bit product in HI/LO.
module mips_mult_ctrl #(
  parameter int N_ITER = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_mult_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] CNT_LAST = 6'(N_ITER - 1);
  localparam logic [2:0] OP_ADD   = 3'b010;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  logic        run;
  logic        accept;

  assign run    = (state_q == S_RUN);
  // A new request is only heard when the controller is not holding the ALU.
  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          mcand_d = bus.mcand;
          hi_d    = '0;
          lo_d    = bus.mplier;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // The carry out becomes bit 63 of the partial; dropping it breaks large operands.
        {hi_d, lo_d} = {bus.alu_cout, bus.alu_r, lo_q[31:1]};
        cnt_d        = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status and ALU steering decode from registered state only.
  assign bus.busy    = run;
  assign bus.alu_own = run;
  assign bus.done    = (state_q == S_DONE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.alu_op  = run ? OP_ADD : 3'b000;
  assign bus.alu_a   = run ? hi_q : 32'd0;
  assign bus.alu_b   = (run && lo_q[0]) ? mcand_q : 32'd0;

endmodule

// File: tb/tb_mips_mult_ctrl.sv
// Directed bench for mips_mult_ctrl with a behavioural adder standing in for the shared ALU.
module tb_mips_mult_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  mips_mult_ctrl_if bus ();

  mips_mult_ctrl #(.N_ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU: 32-bit add, carry-in 0.
  assign {bus.alu_cout, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present a start pulse that is sampled at the next posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // Counts negedges until done; optionally re-pulses start at cycle poke of RUN.
  task automatic wait_done(input int poke, output int lat, output int busy_n, output int own_n);
    lat    = -1;
    busy_n = 0;
    own_n  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (poke != 0 && k == poke) begin
        bus.start  = 1'b1;
        bus.mcand  = 32'hFFFF_FFFF;
        bus.mplier = 32'hFFFF_FFFF;
      end
      if (poke != 0 && k == poke + 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.alu_own && bus.alu_op == 3'b010) own_n++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic mult_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
    int lat, bn, on;
    issue(a, b);
    wait_done(0, lat, bn, on);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_busy"}, 64'(bn), 64'd32);
    check({tag, "_own"}, 64'(on), 64'd32);
    check({tag, "_prod"}, {bus.hi, bus.lo}, exp);
    @(negedge clk);
  endtask

  initial begin
    int lat, bn, on;
    n_vec      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {59'd0, bus.busy, bus.done, bus.alu_own, bus.alu_op[1:0]}, 64'd0);
    check("rst_op", 64'(bus.alu_op), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_alu", {bus.alu_a, bus.alu_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, plus hold and ALU release after done.
    issue(32'd3, 32'd5);
    wait_done(0, lat, bn, on);
    check("basic_lat", 64'(lat), 64'd33);
    check("basic_busy", 64'(bn), 64'd32);
    check("basic_own", 64'(on), 64'd32);
    check("basic_prod", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
    check("done_alu_op", 64'(bus.alu_op), 64'd0);
    @(negedge clk);
    check("idle_done", {63'd0, bus.done}, 64'd0);
    check("idle_hold", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
    check("idle_alu", {bus.alu_a, bus.alu_b}, 64'd0);

    mult_case("ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    mult_case("msb",   32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000);
    mult_case("zero",  32'd0,         32'h1234_5678, 64'd0);
    mult_case("ident", 32'h1234_5678, 32'd1,         64'h0000_0000_1234_5678);
    mult_case("mixed", 32'hDEAD_BEEF, 32'h0000_0100, 64'h0000_00DE_ADBE_EF00);

    // start during RUN must be ignored.
    issue(32'h0000_1234, 32'h0000_0010);
    wait_done(10, lat, bn, on);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_prod", {bus.hi, bus.lo}, 64'h0000_0000_0001_2340);
    @(negedge clk);
    check("ign_norestart", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);

    // Back-to-back: second start presented in the DONE cycle.
    issue(32'h0000_0100, 32'h0000_0100);
    wait_done(0, lat, bn, on);
    check("b2b1_prod", {bus.hi, bus.lo}, 64'h0000_0000_0001_0000);
    issue(32'd7, 32'd6);
    wait_done(0, lat, bn, on);
    check("b2b2_lat", 64'(lat), 64'd33);
    check("b2b2_prod", {bus.hi, bus.lo}, 64'd42);
    @(negedge clk);

    // Reset in the middle of RUN.
    issue(32'hFFFF_FFFF, 32'd3);
    repeat (15) @(negedge clk);
    check("mid_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_ctl", {60'd0, bus.busy, bus.done, bus.alu_own, 1'b0}, 64'd0);
    check("mrst_op", 64'(bus.alu_op), 64'd0);
    check("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("mrst_alu", {bus.alu_a, bus.alu_b}, 64'd0);
    bn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) bn++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) bn++;
    end
    check("mrst_nodone", 64'(bn), 64'd0);
    mult_case("post_rst", 32'd2, 32'd2, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mult_ctrl.md
# mips_mult_ctrl

Multi-cycle unsigned multiply controller (MULTU) for the single-cycle processor. It borrows the shared 32-bit ALU for 32 consecutive add cycles and builds the 64-bit product with a shift-add sequence. The product lands in HI/LO registers. While it holds the ALU it drives the ALU operand mux through `alu_own`, and the datapath must stall.

## Interface
Parameters:
- `N_ITER`, 32: number of shift-add iterations, equal to operand width. Only 32 is supported.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE or DONE.
- `mcand`, input, 32: multiplicand, captured when `start` is accepted.
- `mplier`, input, 32: multiplier, captured when `start` is accepted.
- `busy`, output, 1: high while the multiply is in progress (state RUN).
- `done`, output, 1: one-cycle pulse; `hi`/`lo` are valid.
- `hi`, output, 32: upper product word. Holds until the next accepted `start`.
- `lo`, output, 32: lower product word. Holds until the next accepted `start`.
- `alu_own`, output, 1: high selects controller operands into the shared ALU.
- `alu_op`, output, 3: ALU operation. 3'b010 (add, carry-in 0) in RUN, else 3'b000.
- `alu_a`, output, 32: ALU operand a.
- `alu_b`, output, 32: ALU operand b.
- `alu_r`, input, 32: ALU result, combinational from `alu_a`/`alu_b`.
- `alu_cout`, input, 1: ALU carry out of bit 31.

## Operation
- **States:** IDLE, RUN, DONE. The state register and 6-bit iteration counter `cnt` are the only control state.
- **Reset values** (async, `rst_n`=0): state IDLE, `cnt`=0, `mcand_r`=0, `hi`=0, `lo`=0, `busy`=0, `done`=0, `alu_own`=0, `alu_op`=000, `alu_a`=0, `alu_b`=0.
- **IDLE:**
  - `start`=1: `mcand_r`<=`mcand`, `hi`<=0, `lo`<=`mplier`, `cnt`<=0, go to RUN.
  - `start`=0: stay in IDLE.
- **RUN (one iteration per cycle):**
  - `alu_a`=`hi`; `alu_b`=`lo[0]` ? `mcand_r` : 0; `alu_op`=010.
  - At the edge, {`hi`,`lo`} <= {`alu_cout`, `alu_r`, `lo[31:1]`}, i.e. a 65-bit value shifted right by one. `cnt`<=`cnt`+1.
  - When `cnt`==`N_ITER`-1 at the edge, go to DONE.
- **DONE:**
  - `done`=1 and `hi`/`lo` equal the full 64-bit product {`hi`,`lo`} = `mcand` * `mplier` (unsigned).
  - `start`=1: load exactly as in IDLE and go to RUN (back-to-back issue, no idle bubble).
  - `start`=0: go to IDLE.
- `start` in RUN is ignored; operands and progress are unaffected.
- Width rule: the carry out of the 32-bit add must be kept as product bit 63 of the current partial. Dropping it corrupts the result when both operands are large.
- Overflow is impossible, since the product always fits in 64 bits. ALU `z`/`v` are not used.
- Reset asserted mid-RUN: immediate abort to reset values. No done pulse; partial product discarded.

## Timing
- `busy`, `alu_own` and `done` decode from the state register only (no combinational path from `start`).
- `alu_a`/`alu_b`/`alu_op` are combinational from registered state and are forced to 0/0/000 outside RUN.
- Latency: `start` sampled at edge E0, RUN spans cycles E0..E32, `done`=1 in the cycle after E32. This is 33 cycles from the accepting edge to the `done` cycle.
- `alu_own`=1 for exactly 32 cycles per multiply. The datapath ALU mux must follow `alu_own` in the same cycle.
- The ALU path `alu_a`/`alu_b` -> `alu_r`/`alu_cout` -> `hi` register is the critical path and must close in one cycle.
- Throughput with back-to-back `start` in DONE: one result every 33 cycles.

## Test plan
- Basic: `mcand`=3, `mplier`=5, `start` pulse -> `done` 33 cycles later with `hi`=0x00000000, `lo`=0x0000000F; `busy`/`alu_own` high exactly 32 cycles.
- Carry path: 0xFFFFFFFF * 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. 0x80000000 * 2 -> `hi`=0x00000001, `lo`=0x00000000.
- Zero and identity: 0 * 0x12345678 -> `hi`=0, `lo`=0. 0x12345678 * 1 -> `hi`=0, `lo`=0x12345678.
- Ignored start: re-pulse `start` with new operands at cycle 10 of RUN -> the result is still the first product, `done` still at cycle 33, no restart.
- Back-to-back: hold `start`=1 in the DONE cycle with 7*6 -> second `done` exactly 33 cycles after the first, product 42.
- Reset mid-run: drop `rst_n` at cycle 15 of RUN -> all outputs at reset values in the same cycle, no `done`. After release, a fresh 2*2 yields `lo`=4.
